// File: rtl/tdm_pkg.sv
// Shared constants and helpers for the TDM mask scheduler and its keystream LFSR.
package tdm_pkg;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // Width of a slot index; never collapses below one bit.
  function automatic int slot_w(input int num_slots);
    return (num_slots > 1) ? $clog2(num_slots) : 1;
  endfunction

endpackage

// File: rtl/lfsr16_galois.sv
// 16-bit right-shifting Galois LFSR; advances one step per cycle that step is high.
module lfsr16_galois
  import tdm_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED,
  parameter logic [15:0] TAPS = LFSR_TAPS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step,
  output logic [15:0] state
);

  logic [15:0] state_next;

  always_comb begin
    state_next = state;
    if (load) begin
      state_next = SEED;
    end else if (step) begin
      state_next = {1'b0, state[15:1]} ^ (state[0] ? TAPS : 16'h0000);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEED;
    end else begin
      state <= state_next;
    end
  end

endmodule

// File: rtl/tdm_mask_scheduler.sv
// Round-robin TDM of NUM_SLOTS sources onto one channel, each accepted word
// paired with a single-use LFSR mask for the downstream XOR stage.
module tdm_mask_scheduler
  import tdm_pkg::*;
#(
  parameter int          WIDTH     = 8,
  parameter int          NUM_SLOTS = 4,
  parameter int          SLOT_LEN  = 16,
  parameter logic [15:0] SEED      = DEFAULT_SEED
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic [NUM_SLOTS*WIDTH-1:0]     src_data,
  input  logic [NUM_SLOTS-1:0]           src_valid,
  output logic [NUM_SLOTS-1:0]           src_ready,
  output logic [WIDTH-1:0]               out_data,
  output logic [WIDTH-1:0]               out_mask,
  output logic [slot_w(NUM_SLOTS)-1:0]   out_slot,
  output logic                           out_valid,
  input  logic                           out_ready
);

  localparam int SW = slot_w(NUM_SLOTS);
  localparam int CW = $clog2(SLOT_LEN);

  logic [SW-1:0]    slot_reg;
  logic [CW-1:0]    cyc_reg;
  logic             grant;
  logic             xfer;
  logic [WIDTH-1:0] cur_word;
  logic [15:0]      lfsr_state;
  logic             unused_lfsr_bits;

  // Only the current slot may be granted, and only when the output register can take a word.
  assign grant = en && (!out_valid || out_ready);

  generate
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_ready
      assign src_ready[gi] = grant && (slot_reg == SW'(gi));
    end
  endgenerate

  assign xfer     = src_valid[slot_reg] && src_ready[slot_reg];
  assign cur_word = src_data[int'(slot_reg)*WIDTH +: WIDTH];

  assign unused_lfsr_bits = ^lfsr_state;

  lfsr16_galois #(
    .SEED (SEED),
    .TAPS (LFSR_TAPS)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (1'b0),
    .step  (xfer),
    .state (lfsr_state)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_reg <= '0;
      cyc_reg  <= '0;
    end else if (en) begin
      if (cyc_reg == CW'(SLOT_LEN - 1)) begin
        cyc_reg  <= '0;
        slot_reg <= slot_reg + SW'(1);
      end else begin
        cyc_reg <= cyc_reg + CW'(1);
      end
    end
  end

  // A held word keeps its captured slot even after the slot counter moves on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_mask  <= '0;
      out_slot  <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= cur_word;
      out_mask  <= lfsr_state[WIDTH-1:0];
      out_slot  <= slot_reg;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tdm_mask_scheduler.sv
// Scoreboard bench: a reference model predicts each transfer and its mask, and outputs are checked in order.
module tb_tdm_mask_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [31:0] src_data = '0;
  logic [3:0]  src_valid = '0;
  logic [3:0]  src_ready;
  logic [7:0]  out_data;
  logic [7:0]  out_mask;
  logic [1:0]  out_slot;
  logic        out_valid;
  logic        out_ready = 1'b0;

  tdm_mask_scheduler #(
    .WIDTH     (8),
    .NUM_SLOTS (4),
    .SLOT_LEN  (16),
    .SEED      (16'hACE1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .src_data  (src_data),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .out_data  (out_data),
    .out_mask  (out_mask),
    .out_slot  (out_slot),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  int          m_slot;
  int          m_cyc;
  logic [15:0] m_lfsr;
  logic        m_ov;
  logic [17:0] sb_q[$];   // {slot, mask, data}

  // popped words since last reset
  logic [7:0] hist_data[64];
  logic [7:0] hist_mask[64];
  logic [1:0] hist_slot[64];
  int         hist_n;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_slot = 0;
    m_cyc  = 0;
    m_lfsr = 16'hACE1;
    m_ov   = 1'b0;
    sb_q.delete();
    hist_n = 0;
  endtask

  // One clock: compare at the falling edge, advance the model, return just after the rising edge.
  task automatic cycle();
    logic [3:0]  exp_ready;
    logic        xfer;
    logic [17:0] front;
    @(negedge clk);
    exp_ready = (rst_n && en && (!m_ov || out_ready)) ? (4'b0001 << m_slot) : 4'b0000;
    if (!rst_n) exp_ready = en ? 4'b0001 : 4'b0000;
    check("src_ready", src_ready, exp_ready);
    check("out_valid", out_valid, m_ov);
    if (rst_n && out_valid) begin
      check("q_nonempty", sb_q.size() != 0, 1);
      if (sb_q.size() != 0) begin
        front = sb_q[0];
        check("out_data", out_data, front[7:0]);
        check("out_mask", out_mask, front[15:8]);
        check("out_slot", out_slot, front[17:16]);
        if (out_ready) begin
          void'(sb_q.pop_front());
          $display("word slot=%0d data=%02h mask=%02h", out_slot, out_data, out_mask);
          if (hist_n < 64) begin
            hist_data[hist_n] = out_data;
            hist_mask[hist_n] = out_mask;
            hist_slot[hist_n] = out_slot;
            hist_n++;
          end
        end
      end
    end
    if (rst_n) begin
      xfer = exp_ready[m_slot] && src_valid[m_slot];
      if (xfer) begin
        sb_q.push_back({2'(m_slot), m_lfsr[7:0], src_data[m_slot*8 +: 8]});
        m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
        m_ov = 1'b1;
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
      if (en) begin
        if (m_cyc == 15) begin
          m_cyc  = 0;
          m_slot = (m_slot + 1) % 4;
        end else begin
          m_cyc++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_mask", out_mask, 0);
    check("rst_out_slot", out_slot, 0);
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic rand_data();
    src_data = $urandom;
  endtask

  initial begin
    model_reset();

    // T1: all sources valid, downstream always ready
    en = 1'b1; out_ready = 1'b1; src_valid = 4'hF;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      rand_data();
      cycle();
    end
    check("t1_mask0", hist_mask[0], 8'hE1);
    check("t1_mask1", hist_mask[1], 8'h70);
    check("t1_mask2", hist_mask[2], 8'h38);
    check("t1_slot15", hist_slot[15], 0);
    check("t1_slot16", hist_slot[16], 1);

    // T2: only source 2 valid
    src_valid = 4'b0100; src_data = 32'h005A_0000;
    do_reset();
    for (int i = 0; i < 50; i++) cycle();
    check("t2_data0", hist_data[0], 8'h5A);
    check("t2_slot0", hist_slot[0], 2);
    check("t2_mask0", hist_mask[0], 8'hE1);

    // T3: downstream stalls after the first capture
    src_valid = 4'hF; out_ready = 1'b1;
    do_reset();
    rand_data();
    cycle();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rand_data();
      cycle();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_data();
      cycle();
    end
    check("t3_mask0", hist_mask[0], 8'hE1);
    check("t3_mask1", hist_mask[1], 8'h70);

    // T4: word captured on the last cycle of slot 0, held across the boundary
    do_reset();
    for (int i = 0; i < 16; i++) begin
      rand_data();
      cycle();
    end
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rand_data();
      cycle();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rand_data();
      cycle();
    end
    check("t4_slot15", hist_slot[15], 0);
    check("t4_slot16", hist_slot[16], 1);

    // T5: en low for five cycles mid-slot while a word drains
    do_reset();
    for (int i = 0; i < 6; i++) begin
      rand_data();
      cycle();
    end
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rand_data();
      cycle();
    end
    en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rand_data();
      cycle();
    end
    check("t5_slot15", hist_slot[15], 0);
    check("t5_slot16", hist_slot[16], 1);

    // T6: random traffic, then an asynchronous reset mid-slot with a word pending
    for (int i = 0; i < 300; i++) begin
      rand_data();
      src_valid = 4'($urandom);
      en        = ($urandom_range(0, 7) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    src_valid = 4'hF; en = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_data();
      cycle();
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", out_valid, 0);
    model_reset();
    cycle();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rand_data();
      cycle();
    end
    check("t6_mask0", hist_mask[0], 8'hE1);
    check("t6_slot0", hist_slot[0], 0);

    out_ready = 1'b1; src_valid = 4'h0;
    for (int i = 0; i < 3; i++) cycle();
    check("sb_drained", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
